// File: rtl/bnn_fc_pkg.sv
// Shared types for the binary-weight FC sequencer: pixel type and FSM state encoding.
// No logic, so no latency or backpressure of its own.
package bnn_fc_pkg;

   localparam int PIX_W = 9;

   typedef logic signed [PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_COMPUTE = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

endpackage

// File: rtl/bnn_fc_sequencer_if.sv
// Pixel-in, weight-memory and sum-out signals of the FC sequencer; master is the sequencer side.
// Handshake only; valid/ready on pixels and sums, fixed 1-cycle read latency on weights.
interface bnn_fc_sequencer_if
   import bnn_fc_pkg::*;
#(
   parameter int ACC_W   = 16,
   parameter int WADDR_W = 8,
   parameter int NEU_W   = 2
);

   logic                     in_valid;
   logic                     in_ready;
   pix_t                     in_pixel;
   logic                     wt_rd_en;
   logic [WADDR_W-1:0]       wt_addr;
   logic                     wt_bit;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  out_data;
   logic [NEU_W-1:0]         out_neuron;
   logic                     busy;

   modport master (
      input  in_valid, in_pixel, wt_bit, out_ready,
      output in_ready, wt_rd_en, wt_addr, out_valid, out_data, out_neuron, busy
   );

   modport slave (
      output in_valid, in_pixel, wt_bit, out_ready,
      input  in_ready, wt_rd_en, wt_addr, out_valid, out_data, out_neuron, busy
   );

endinterface

// File: rtl/bw_sign_unit.sv
// Applies a binary weight to a pixel: bit 1 passes, bit 0 negates (9-bit wrap, no saturation).
// Purely combinational, zero latency, no backpressure.
module bw_sign_unit
   import bnn_fc_pkg::*;
(
   input  pix_t pixel,
   input  logic wt_bit,
   output pix_t product
);

   assign product = wt_bit ? pixel : pix_t'(~pixel + pix_t'(1));

endmodule

// File: rtl/bnn_fc_sequencer.sv
// Buffers IN_LEN pixels, then for each neuron streams weights and accumulates; IN_LEN+2 cycles per sum.
// Backpressure: input stalls outside LOAD; a held out_ready freezes the sum and stops weight reads.
module bnn_fc_sequencer
   import bnn_fc_pkg::*;
#(
   parameter int IN_LEN  = 16,
   parameter int NUM_OUT = 4,
   parameter int ACC_W   = 16,
   parameter int WADDR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   bnn_fc_sequencer_if.master bus
);

   localparam int IDX_W = $clog2(IN_LEN);
   localparam int CNT_W = $clog2(IN_LEN + 1);
   localparam int NEU_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        load_idx;
   logic [CNT_W-1:0]        issue_cnt;
   logic [NEU_W-1:0]        neuron;
   logic signed [ACC_W-1:0] acc;
   pix_t                    pix_buf [IN_LEN];
   pix_t                    pix_q;
   pix_t                    prod;
   logic                    acc_vld_q;
   logic                    acc_last_q;

   logic                    load_fire;
   logic                    load_last;
   logic                    issuing;
   logic                    issue_last;
   logic                    out_fire;
   logic                    last_neuron;

   bw_sign_unit u_sign (
      .pixel   (pix_q),
      .wt_bit  (bus.wt_bit),
      .product (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_fire      = 1'b0;
      load_last      = 1'b0;
      issuing        = 1'b0;
      issue_last     = 1'b0;
      out_fire       = 1'b0;
      last_neuron    = (neuron == NEU_W'(NUM_OUT - 1));
      bus.in_ready   = 1'b0;
      bus.busy       = 1'b1;
      bus.out_valid  = 1'b0;
      bus.wt_rd_en   = 1'b0;
      bus.wt_addr    = '0;
      bus.out_data   = acc;
      bus.out_neuron = neuron;

      unique case (state)
         S_LOAD: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            load_fire    = bus.in_valid;
            load_last    = load_fire && (load_idx == IDX_W'(IN_LEN - 1));
            if (load_last) state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            // Issue runs while the counter is short of IN_LEN; the last product lands one cycle later.
            issuing      = (issue_cnt != CNT_W'(IN_LEN));
            issue_last   = issuing && (issue_cnt == CNT_W'(IN_LEN - 1));
            bus.wt_rd_en = issuing;
            if (issuing)
               bus.wt_addr = WADDR_W'(neuron) * WADDR_W'(IN_LEN) + WADDR_W'(issue_cnt);
            if (acc_last_q) state_nxt = S_OUTPUT;
         end
         S_OUTPUT: begin
            bus.out_valid = 1'b1;
            out_fire      = bus.out_ready;
            if (out_fire) state_nxt = last_neuron ? S_LOAD : S_COMPUTE;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_idx   <= '0;
         issue_cnt  <= '0;
         neuron     <= '0;
         acc        <= '0;
         pix_q      <= '0;
         acc_vld_q  <= 1'b0;
         acc_last_q <= 1'b0;
      end else begin
         acc_vld_q  <= issuing;
         acc_last_q <= issue_last;
         if (issuing) begin
            pix_q     <= pix_buf[issue_cnt[IDX_W-1:0]];
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         if (acc_vld_q)
            acc <= acc + {{(ACC_W - PIX_W){prod[PIX_W-1]}}, prod};
         if (load_fire)
            load_idx <= load_last ? '0 : load_idx + IDX_W'(1);
         if (load_last) begin
            neuron    <= '0;
            acc       <= '0;
            issue_cnt <= '0;
         end
         if (out_fire) begin
            acc       <= '0;
            issue_cnt <= '0;
            neuron    <= last_neuron ? '0 : neuron + NEU_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_fire) pix_buf[load_idx] <= bus.in_pixel;
   end

endmodule

// File: tb/tb_bnn_fc_sequencer.sv
// Directed plus randomized checks of the FC sequencer against a sum-of-signed-products model.
// Weight memory responds with one cycle of read latency.
module tb_bnn_fc_sequencer;

   localparam int IN_LEN  = 4;
   localparam int NUM_OUT = 2;
   localparam int ACC_W   = 16;
   localparam int WADDR_W = 8;

   logic clk;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   int   pix  [IN_LEN];
   bit   wmem [IN_LEN*NUM_OUT];

   bnn_fc_sequencer_if #(.ACC_W(ACC_W), .WADDR_W(WADDR_W), .NEU_W(1)) bus ();

   bnn_fc_sequencer #(
      .IN_LEN (IN_LEN),
      .NUM_OUT(NUM_OUT),
      .ACC_W  (ACC_W),
      .WADDR_W(WADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      bus.wt_bit <= bus.wt_rd_en ? wmem[bus.wt_addr] : 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Each term is +p or -p, folded back into 9 bits; the total wraps at ACC_W bits.
   function automatic logic [ACC_W-1:0] ref_sum(input int n);
      int s = 0;
      int v;
      for (int i = 0; i < IN_LEN; i++) begin
         v = wmem[n*IN_LEN + i] ? pix[i] : -pix[i];
         if (v == 256) v = -256;
         s += v;
      end
      return ACC_W'(s);
   endfunction

   task automatic load_vec(input bit stall, output int t_last);
      t_last = 0;
      for (int i = 0; i < IN_LEN; i++) begin
         chk("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
         bus.in_valid = 1'b1;
         bus.in_pixel = 9'(pix[i]);
         t_last = cyc;
         @(negedge clk);
         if (stall && i < IN_LEN - 1) begin
            bus.in_valid = 1'b0;
            bus.in_pixel = 9'($urandom);
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_outputs(input int t_start, input int bp);
      int t_ref;
      int rd;
      int guard;
      bit got;
      t_ref = t_start;
      for (int j = 0; j < NUM_OUT; j++) begin
         rd = 0;
         guard = 0;
         got = 1'b0;
         while (!got) begin
            chk("busy", {31'd0, bus.busy}, 32'd1);
            chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
            if (bus.wt_rd_en) begin
               chk("wt_addr", {24'd0, bus.wt_addr}, 32'(j*IN_LEN + rd));
               rd++;
            end
            if (bus.out_valid) begin
               got = 1'b1;
               chk("latency", 32'(cyc), 32'(t_ref + IN_LEN + 2));
               chk("rd_count", 32'(rd), 32'(IN_LEN));
               chk("out_data", {16'd0, bus.out_data}, {16'd0, ref_sum(j)});
               chk("out_neuron", {31'd0, bus.out_neuron}, 32'(j));
               if (j == 0 && bp > 0) begin
                  bus.out_ready = 1'b0;
                  for (int k = 0; k < bp; k++) begin
                     @(negedge clk);
                     chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                     chk("hold_data", {16'd0, bus.out_data}, {16'd0, ref_sum(0)});
                     chk("hold_neuron", {31'd0, bus.out_neuron}, 32'd0);
                     chk("hold_no_rd", {31'd0, bus.wt_rd_en}, 32'd0);
                  end
                  bus.out_ready = 1'b1;
               end
               t_ref = cyc;
            end
            @(negedge clk);
            guard++;
            if (guard > 100) begin
               chk("timeout_out_valid", {31'd0, bus.out_valid}, 32'd1);
               return;
            end
         end
      end
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_rd_en", {31'd0, bus.wt_rd_en}, 32'd0);
   endtask

   task automatic set_vec(input int p0, input int p1, input int p2, input int p3,
                          input logic [7:0] w);
      pix[0] = p0; pix[1] = p1; pix[2] = p2; pix[3] = p3;
      for (int i = 0; i < IN_LEN*NUM_OUT; i++) wmem[i] = w[i];
   endtask

   initial begin
      int t;
      int r;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
      chk("rst_out_neuron", {31'd0, bus.out_neuron}, 32'd0);
      chk("rst_rd_en", {31'd0, bus.wt_rd_en}, 32'd0);
      chk("rst_wt_addr", {24'd0, bus.wt_addr}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // n0 all ones, n1 = {0,1,0,1} (bit i of neuron 1 is w[4+i])
      set_vec(10, -3, 7, 0, 8'b1010_1111);
      load_vec(1'b0, t);
      run_outputs(t, 0);

      load_vec(1'b0, t);
      run_outputs(t, 5);

      set_vec(-256, 255, -1, 1, 8'b0000_0000);
      load_vec(1'b0, t);
      run_outputs(t, 0);

      set_vec(1, 2, 3, 4, 8'b1111_1111);
      load_vec(1'b1, t);
      run_outputs(t, 0);

      set_vec(10, -3, 7, 0, 8'b1010_1111);
      load_vec(1'b0, t);
      chk("mid_rd_en0", {31'd0, bus.wt_rd_en}, 32'd1);
      chk("mid_addr0", {24'd0, bus.wt_addr}, 32'd0);
      @(negedge clk);
      chk("mid_rd_en1", {31'd0, bus.wt_rd_en}, 32'd1);
      chk("mid_addr1", {24'd0, bus.wt_addr}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_rd_en", {31'd0, bus.wt_rd_en}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      set_vec(-7, 100, 33, -128, 8'b0110_1001);
      load_vec(1'b0, t);
      run_outputs(t, 0);

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < IN_LEN; i++) begin
            r = int'($urandom_range(511, 0));
            pix[i] = r - 256;
         end
         for (int i = 0; i < IN_LEN*NUM_OUT; i++) wmem[i] = 1'($urandom);
         load_vec(1'($urandom), t);
         run_outputs(t, int'($urandom_range(3, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
